// File: rtl/game_ctrl.sv
// Frogger-style game controller: menu, round timer, lives, level,
// and the DEAD / WIN hold screens, all driven from a one-second tick.
module game_ctrl #(
   parameter int TICK_DIV      = 25_000_000,
   parameter int ROUND_SECONDS = 30,
   parameter int LIVES_INIT    = 3,
   parameter int DEAD_HOLD     = 2,
   parameter int WIN_HOLD      = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_btn,
   input  logic       reached_end,
   input  logic       collision,
   output logic [1:0] state,
   output logic [1:0] lives,
   output logic [3:0] level,
   output logic [5:0] time_left,
   output logic       frog_reset
);

   typedef enum logic [1:0] {
      S_MENU    = 2'd0,
      S_PLAYING = 2'd1,
      S_DEAD    = 2'd2,
      S_WIN     = 2'd3
   } state_t;

   localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
   localparam logic [31:0] DEAD_LAST = 32'(DEAD_HOLD - 1);
   localparam logic [31:0] WIN_LAST  = 32'(WIN_HOLD - 1);
   localparam logic [1:0]  LIVES_RST = 2'(LIVES_INIT);
   localparam logic [5:0]  ROUND_RLD = 6'(ROUND_SECONDS);

   state_t      st_q, st_d;
   logic [1:0]  lives_d;
   logic [3:0]  level_d;
   logic [5:0]  time_d;
   logic        fr_d;
   logic [31:0] sec_q, sec_d;
   logic [31:0] hold_q, hold_d;
   logic        btn_q;
   logic        start_edge;
   logic        sec_tick;
   logic        timeout;
   logic        death;

   assign state      = st_q;
   assign start_edge = start_btn & ~btn_q;
   assign sec_tick   = (st_q != S_MENU) && (sec_q == TICK_LAST);
   assign timeout    = sec_tick && (time_left == 6'd1);
   assign death      = collision || timeout;

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q       <= S_MENU;
         lives      <= LIVES_RST;
         level      <= 4'd0;
         time_left  <= ROUND_RLD;
         frog_reset <= 1'b0;
         sec_q      <= 32'd0;
         hold_q     <= 32'd0;
         btn_q      <= 1'b1;
      end else begin
         st_q       <= st_d;
         lives      <= lives_d;
         level      <= level_d;
         time_left  <= time_d;
         frog_reset <= fr_d;
         sec_q      <= sec_d;
         hold_q     <= hold_d;
         btn_q      <= start_btn;
      end
   end

   always_comb begin
      st_d    = st_q;
      lives_d = lives;
      level_d = level;
      time_d  = time_left;
      fr_d    = 1'b0;
      hold_d  = hold_q;
      sec_d   = 32'd0;

      unique case (st_q)
         S_MENU: begin
            if (start_edge) begin
               st_d    = S_PLAYING;
               lives_d = LIVES_RST;
               level_d = 4'd0;
               time_d  = ROUND_RLD;
               fr_d    = 1'b1;
            end
         end
         S_PLAYING: begin
            if (sec_tick)
               time_d = time_left - 6'd1;
            // death outranks reaching the end in the same cycle
            if (death) begin
               if (timeout)
                  time_d = 6'd0;
               if (lives != 2'd0)
                  lives_d = lives - 2'd1;
               st_d = S_DEAD;
            end else if (reached_end) begin
               if (level != 4'd15)
                  level_d = level + 4'd1;
               st_d = S_WIN;
            end
         end
         S_DEAD: begin
            if (sec_tick) begin
               if (hold_q == DEAD_LAST) begin
                  if (lives == 2'd0) begin
                     st_d = S_MENU;
                  end else begin
                     st_d   = S_PLAYING;
                     time_d = ROUND_RLD;
                     fr_d   = 1'b1;
                  end
               end else begin
                  hold_d = hold_q + 32'd1;
               end
            end
         end
         S_WIN: begin
            if (sec_tick) begin
               if (hold_q == WIN_LAST) begin
                  st_d   = S_PLAYING;
                  time_d = ROUND_RLD;
                  fr_d   = 1'b1;
               end else begin
                  hold_d = hold_q + 32'd1;
               end
            end
         end
         default: st_d = S_MENU;
      endcase

      if (st_d != st_q) begin
         sec_d  = 32'd0;
         hold_d = 32'd0;
      end else if (st_q == S_MENU || sec_tick) begin
         sec_d = 32'd0;
      end else begin
         sec_d = sec_q + 32'd1;
      end
   end

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed vector table followed by random stimulus,
// every cycle also checked against an edge-counting reference model.
module tb_game_ctrl;

   localparam int TD = 4;
   localparam int RS = 3;
   localparam int LI = 3;
   localparam int DH = 1;
   localparam int WH = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start_btn = 1'b0;
   logic       reached_end = 1'b0;
   logic       collision = 1'b0;
   logic [1:0] state;
   logic [1:0] lives;
   logic [3:0] level;
   logic [5:0] time_left;
   logic       frog_reset;

   always #5 clk = ~clk;

   game_ctrl #(
      .TICK_DIV(TD),
      .ROUND_SECONDS(RS),
      .LIVES_INIT(LI),
      .DEAD_HOLD(DH),
      .WIN_HOLD(WH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start_btn(start_btn),
      .reached_end(reached_end),
      .collision(collision),
      .state(state),
      .lives(lives),
      .level(level),
      .time_left(time_left),
      .frog_reset(frog_reset)
   );

   typedef struct {
      logic       rst;
      logic       sb;
      logic       re;
      logic       col;
      logic [1:0] st;
      logic [1:0] li;
      logic [3:0] lv;
      logic [5:0] tl;
      logic       fr;
   } vec_t;

   vec_t vq[$];

   int errors = 0;
   int checks = 0;

   int m_st = 0, m_li = 0, m_lv = 0, m_tl = 0, m_fr = 0;
   int m_prev = 1, m_k = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // m_k = edges since entering the current state; a second elapses
   // every TD edges, and the hold ends after the required seconds.
   task automatic model(input logic r, input logic sb,
                        input logic re, input logic col);
      int k1;
      int ns;
      bit sedge;
      bit tick;
      bit tout;
      if (r) begin
         m_st = 0; m_li = LI; m_lv = 0; m_tl = RS;
         m_fr = 0; m_prev = 1; m_k = 0;
         return;
      end
      sedge  = sb && (m_prev == 0);
      m_prev = sb;
      m_fr   = 0;
      ns     = m_st;
      k1     = (m_st != 0) ? m_k + 1 : 0;
      tick   = (m_st != 0) && (k1 % TD == 0);
      case (m_st)
         0: if (sedge) begin
            ns = 1; m_li = LI; m_lv = 0; m_tl = RS; m_fr = 1;
         end
         1: begin
            tout = tick && (m_tl == 1);
            if (tick) m_tl--;
            if (col || tout) begin
               if (m_li > 0) m_li--;
               ns = 2;
            end else if (re) begin
               if (m_lv < 15) m_lv++;
               ns = 3;
            end
         end
         2: if (tick && k1 / TD == DH) begin
            if (m_li == 0) ns = 0;
            else begin ns = 1; m_tl = RS; m_fr = 1; end
         end
         3: if (tick && k1 / TD == WH) begin
            ns = 1; m_tl = RS; m_fr = 1;
         end
         default: ;
      endcase
      m_k  = (ns != m_st) ? 0 : k1;
      m_st = ns;
   endtask

   task automatic step(input logic r, input logic sb,
                       input logic re, input logic col);
      @(negedge clk);
      reset = r; start_btn = sb; reached_end = re; collision = col;
      @(posedge clk);
      model(r, sb, re, col);
      #1;
      chk("model_state", int'(state), m_st);
      chk("model_lives", int'(lives), m_li);
      chk("model_level", int'(level), m_lv);
      chk("model_time", int'(time_left), m_tl);
      chk("model_frog_reset", int'(frog_reset), m_fr);
   endtask

   task automatic add(input logic r, input logic sb,
                      input logic re, input logic col,
                      input logic [1:0] st, input logic [1:0] li,
                      input logic [3:0] lv, input logic [5:0] tl,
                      input logic fr, input int n);
      vec_t v;
      v.rst = r; v.sb = sb; v.re = re; v.col = col;
      v.st = st; v.li = li; v.lv = lv; v.tl = tl; v.fr = fr;
      for (int i = 0; i < n; i++) vq.push_back(v);
   endtask

   initial begin
      int lv;
      // reset, start, timeout death, respawn
      add(1,0,0,0, 0,3,0,3,0, 2);
      add(0,0,0,0, 0,3,0,3,0, 2);
      add(0,1,0,0, 1,3,0,3,1, 1);
      add(0,0,0,0, 1,3,0,3,0, 3);
      add(0,0,0,0, 1,3,0,2,0, 4);
      add(0,0,0,0, 1,3,0,1,0, 4);
      add(0,0,0,0, 2,2,0,0,0, 4);
      add(0,0,0,0, 1,2,0,3,1, 1);
      // collision and reached_end together: death wins
      add(0,0,1,1, 2,1,0,3,0, 1);
      add(0,0,0,0, 2,1,0,3,0, 3);
      add(0,0,0,0, 1,1,0,3,1, 1);
      // win, inputs ignored during hold
      add(0,0,1,0, 3,1,1,3,0, 1);
      add(0,1,0,1, 3,1,1,3,0, 3);
      add(0,0,0,0, 1,1,1,3,1, 1);
      // last life lost, back to menu
      add(0,0,0,1, 2,0,1,3,0, 1);
      add(0,0,0,0, 2,0,1,3,0, 3);
      add(0,0,0,0, 0,0,1,3,0, 1);
      add(0,0,1,1, 0,0,1,3,0, 2);
      add(0,1,0,0, 1,3,0,3,1, 1);
      // reset in the middle of DEAD
      add(0,0,0,1, 2,2,0,3,0, 1);
      add(0,0,0,0, 2,2,0,3,0, 1);
      add(1,0,0,0, 0,3,0,3,0, 1);
      // button held through reset gives no edge
      add(1,1,0,0, 0,3,0,3,0, 1);
      add(0,1,0,0, 0,3,0,3,0, 3);
      add(0,0,0,0, 0,3,0,3,0, 1);
      add(0,1,0,0, 1,3,0,3,1, 1);
      // level saturates at 15
      for (int i = 1; i <= 16; i++) begin
         lv = (i > 15) ? 15 : i;
         add(0,0,1,0, 3,3,4'(lv),3,0, 1);
         add(0,0,0,0, 3,3,4'(lv),3,0, 3);
         add(0,0,0,0, 1,3,4'(lv),3,1, 1);
      end

      foreach (vq[i]) begin
         step(vq[i].rst, vq[i].sb, vq[i].re, vq[i].col);
         chk($sformatf("vec%0d_state", i), int'(state), int'(vq[i].st));
         chk($sformatf("vec%0d_lives", i), int'(lives), int'(vq[i].li));
         chk($sformatf("vec%0d_level", i), int'(level), int'(vq[i].lv));
         chk($sformatf("vec%0d_time", i), int'(time_left), int'(vq[i].tl));
         chk($sformatf("vec%0d_frog_reset", i), int'(frog_reset),
             int'(vq[i].fr));
      end

      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(199) == 0),
              ($urandom_range(3) == 0),
              ($urandom_range(7) == 0),
              ($urandom_range(9) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25_000_000; clock cycles per one-second tick, at least 2.
REQ-002 SHALL have parameter ROUND_SECONDS, default 30; round time reload value, range 1..63.
REQ-003 SHALL have parameter LIVES_INIT, default 3; lives at game start, range 1..3.
REQ-004 SHALL have parameter DEAD_HOLD, default 2; seconds spent in DEAD, at least 1.
REQ-005 SHALL have parameter WIN_HOLD, default 3; seconds spent in WIN, at least 1.
REQ-006 SHALL have port clk  in  1  system clock; single clock domain.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port start_btn  in  1  debounced start button level.
REQ-009 SHALL have port reached_end  in  1  frog is in the end area.
REQ-010 SHALL have port collision  in  1  frog overlaps a hazard.
REQ-011 SHALL have port state  out  2  game state: MENU=0, PLAYING=1, DEAD=2, WIN=3.
REQ-012 SHALL have port lives  out  2  remaining lives.
REQ-013 SHALL have port level  out  4  levels completed.
REQ-014 SHALL have port time_left  out  6  seconds remaining in the round.
REQ-015 SHALL have port frog_reset  out  1  one-cycle pulse that returns the frog to its start position.

Function
REQ-016 All outputs SHALL be registered; inputs are sampled at posedge clk.
REQ-017 A start edge SHALL be start_btn=1 while the previous sample was 0; the previous-sample register resets to 1, so a button held through reset gives no edge.
REQ-018 The second counter SHALL clear to 0 on every state change and increment each cycle in PLAYING, DEAD and WIN.
REQ-019 The second counter SHALL assert sec_tick when count==TICK_DIV-1 and wrap to 0; the first sec_tick takes effect TICK_DIV edges after state entry.
REQ-020 In MENU, a start edge SHALL move to PLAYING with lives=LIVES_INIT, level=0, time_left=ROUND_SECONDS and frog_reset=1.
REQ-021 In MENU, collision and reached_end SHALL be ignored.
REQ-022 In PLAYING, sec_tick SHALL decrement time_left by 1.
REQ-023 In PLAYING, a death event SHALL be collision=1, or sec_tick with time_left==1.
REQ-024 On a death event, the block SHALL set time_left=0 only for a timeout, set lives=lives-1 saturating at 0, and move to DEAD.
REQ-025 In PLAYING, reached_end=1 without a death event SHALL move to WIN with level=level+1, saturating at 15.
REQ-026 When death and reached_end occur in the same cycle, death SHALL win, and level SHALL be unchanged.
REQ-027 In DEAD, on the DEAD_HOLD-th sec_tick the block SHALL move to MENU if lives==0.
REQ-028 In DEAD, on the DEAD_HOLD-th sec_tick with lives>0, the block SHALL move to PLAYING with time_left=ROUND_SECONDS and frog_reset=1.
REQ-029 In WIN, on the WIN_HOLD-th sec_tick the block SHALL move to PLAYING with time_left=ROUND_SECONDS and frog_reset=1.
REQ-030 The hold seconds counter SHALL clear on state entry.
REQ-031 Inputs SHALL be ignored during DEAD and WIN.
REQ-032 frog_reset SHALL be high for exactly the first cycle of each PLAYING entry and low at all other times.
REQ-033 start_btn SHALL be ignored outside MENU.

Reset
REQ-034 On reset=1 at posedge clk, the block SHALL set state=MENU, lives=LIVES_INIT, level=0, time_left=ROUND_SECONDS, frog_reset=0, and clear both counters.
REQ-035 Reset SHALL take priority over all events, including in the middle of a hold or round.
REQ-036 Outputs SHALL hold their reset values from the first edge after reset deasserts until a start edge.

Verification
REQ-037 The bench SHALL use TICK_DIV=4, ROUND_SECONDS=3, LIVES_INIT=3, DEAD_HOLD=1, WIN_HOLD=1.
REQ-038 Scenario: release reset, pulse start_btn -> state=1, lives=3, time_left=3, frog_reset high exactly 1 cycle.
REQ-039 Scenario: in PLAYING, no inputs -> time_left becomes 2 at edge 4 and 1 at edge 8; at edge 12 state=2, time_left=0, lives=2; at edge 16 state=1, time_left=3, frog_reset pulses.
REQ-040 Scenario: collision=1 and reached_end=1 in the same PLAYING cycle -> state=2, lives decremented, level unchanged.
REQ-041 Scenario: three collisions from the start -> lives goes 2,1,0; after the final DEAD hold state=0; a new start edge restores lives=3, level=0.
REQ-042 Scenario: reached_end=1 -> state=3, level=1; 4 cycles later state=1, time_left=3, frog_reset pulses.
REQ-043 Scenario: hold start_btn=1 through reset deassertion -> state stays 0; release and press again -> state=1.
REQ-044 Scenario: assert reset mid-DEAD -> next cycle state=0, lives=3, level=0, time_left=3.
